// File: rtl/c3aibadapt_rsvd_pkg.sv
// Shared types and constants for the RX async reserved-bit SSR unloader.
package c3aibadapt_rsvd_pkg;

    localparam int RSVD_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } rsvd_state_t;

endpackage

// File: rtl/c3aibadapt_rxasync_rsvd_shreg.sv
// Serial-in shift register with a saturating bit counter; exposes the
// post-shift contents and count so a same-cycle load sees the final bit.
module c3aibadapt_rxasync_rsvd_shreg
    import c3aibadapt_rsvd_pkg::*;
#(
    parameter int WIDTH = RSVD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             shift,
    input  logic             data,
    input  logic             load,
    output logic [WIDTH-1:0] sh_post,
    output logic [CNT_W-1:0] cnt_post
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] sh_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign sh_post[0] = shift ? data : sh_reg[0];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_bit
            assign sh_post[gi] = shift ? sh_reg[gi-1] : sh_reg[gi];
        end
    endgenerate

    always_comb begin
        cnt_post = cnt_reg;
        if (shift && (cnt_reg != CNT_MAX))
            cnt_post = cnt_reg + CNT_W'(1);
    end

    // Contents survive a load; only the count is cleared.
    always_ff @(posedge clk) begin
        if (srst) begin
            sh_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            sh_reg  <= sh_post;
            cnt_reg <= load ? '0 : cnt_post;
        end
    end

endmodule

// File: rtl/c3aibadapt_rxasync_rsvd_unload.sv
// Unloads WIDTH reserved bits from the SSR stream; a frame is accepted only
// when the load strobe sees exactly WIDTH shifted bits.
module c3aibadapt_rxasync_rsvd_unload
    import c3aibadapt_rsvd_pkg::*;
#(
    parameter int   WIDTH     = RSVD_WIDTH,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             rx_clock_async_rx_osc_clk,
    input  logic             rx_reset_async_rx_osc_clk_rst,
    input  logic             rx_async_fabric_hssi_ssr_data,
    input  logic             rx_async_fabric_hssi_ssr_shift,
    input  logic             rx_async_fabric_hssi_ssr_load,
    output logic [WIDTH-1:0] pld_rx_ssr_reserved_out,
    output logic             rx_async_ssr_reserved_upd,
    output logic             rx_async_ssr_frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic             clk;
    logic             srst;
    logic             shift;
    logic             load;
    logic [WIDTH-1:0] sh_post;
    logic [CNT_W-1:0] cnt_post;

    rsvd_state_t      state_reg;
    logic [WIDTH-1:0] rsvd_out_reg;
    logic             upd_reg;
    logic             err_reg;

    assign clk   = rx_clock_async_rx_osc_clk;
    assign srst  = rx_reset_async_rx_osc_clk_rst;
    assign shift = rx_async_fabric_hssi_ssr_shift;
    assign load  = rx_async_fabric_hssi_ssr_load;

    c3aibadapt_rxasync_rsvd_shreg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk      (clk),
        .srst     (srst),
        .shift    (shift),
        .data     (rx_async_fabric_hssi_ssr_data),
        .load     (load),
        .sh_post  (sh_post),
        .cnt_post (cnt_post)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= IDLE;
            rsvd_out_reg <= {WIDTH{RESET_VAL}};
            upd_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            if (load) begin
                state_reg <= IDLE;
                // Judge the frame on the count including any same-cycle shift.
                if (cnt_post == CNT_FULL) begin
                    rsvd_out_reg <= sh_post;
                    upd_reg      <= 1'b1;
                    err_reg      <= 1'b0;
                end else begin
                    err_reg <= 1'b1;
                end
            end else if (shift) begin
                case (state_reg)
                    IDLE:    state_reg <= SHIFT;
                    SHIFT:   state_reg <= (cnt_post == CNT_MAX) ? OVER : SHIFT;
                    default: state_reg <= OVER;
                endcase
            end
        end
    end

    assign pld_rx_ssr_reserved_out   = rsvd_out_reg;
    assign rx_async_ssr_reserved_upd = upd_reg;
    assign rx_async_ssr_frame_err    = err_reg;

endmodule

// File: tb/tb_c3aibadapt_rxasync_rsvd_unload.sv
// Directed bench: per-cycle vector table plus hand sequences for over-length
// frames and mid-frame reset.
module tb_c3aibadapt_rxasync_rsvd_unload;
    import c3aibadapt_rsvd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       data;
    logic       shift;
    logic       load;
    logic [2:0] out;
    logic       upd;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst;
        logic       shift;
        logic       data;
        logic       load;
        logic [2:0] out;
        logic       upd;
        logic       err;
    } vec_t;

    vec_t vq[$];

    c3aibadapt_rxasync_rsvd_unload #(
        .WIDTH     (3),
        .RESET_VAL (1'b0)
    ) dut (
        .rx_clock_async_rx_osc_clk      (clk),
        .rx_reset_async_rx_osc_clk_rst  (rst),
        .rx_async_fabric_hssi_ssr_data  (data),
        .rx_async_fabric_hssi_ssr_shift (shift),
        .rx_async_fabric_hssi_ssr_load  (load),
        .pld_rx_ssr_reserved_out        (out),
        .rx_async_ssr_reserved_upd      (upd),
        .rx_async_ssr_frame_err         (err)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic s, input logic d, input logic l);
        @(negedge clk);
        rst = r; shift = s; data = d; load = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] eo, input logic eu, input logic ee);
        chk({name, ".out"}, int'(out), int'(eo));
        chk({name, ".upd"}, int'(upd), int'(eu));
        chk({name, ".err"}, int'(err), int'(ee));
        $display("[TB] %s out=%b upd=%b err=%b", name, out, upd, err);
    endtask

    task automatic chk_fsm(input string name, input int est, input int ecnt);
        chk({name, ".state"}, int'(dut.state_reg), est);
        chk({name, ".cnt"}, int'(dut.u_shreg.cnt_reg), ecnt);
    endtask

    initial begin
        rst = 1'b1; shift = 1'b0; data = 1'b0; load = 1'b0;

        //                rst s d l  out    u  e
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0}); // reset state
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0}); // reset beats shift+load
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0}); // good frame 101
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0}); // upd one cycle
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0}); // shift+load same cycle
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1}); // short frame
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1}); // err holds
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b0}); // recovery frame
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0}); // first of two loads
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1}); // zero-count load
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1});

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].rst, vq[i].shift, vq[i].data, vq[i].load);
            chk_out($sformatf("vec%0d", i), vq[i].out, vq[i].upd, vq[i].err);
        end
        chk_fsm("after_table", int'(IDLE), 0);

        // Good frame 111, then an over-length frame of 1,0,0,1 plus one extra shift.
        cycle(0, 1, 1, 0); cycle(0, 1, 1, 0); cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 1);
        chk_out("good111", 3'b111, 1'b1, 1'b0);
        cycle(0, 1, 1, 0);
        chk_fsm("over_s1", int'(SHIFT), 1);
        cycle(0, 1, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 1, 0);
        chk_fsm("over_s4", int'(OVER), 4);
        chk_out("over_s4", 3'b111, 1'b0, 1'b0);
        cycle(0, 1, 0, 0);
        chk_fsm("over_s5", int'(OVER), 4);
        chk_out("over_s5", 3'b111, 1'b0, 1'b0);
        cycle(0, 0, 0, 1);
        chk_out("over_load", 3'b111, 1'b0, 1'b1);
        chk_fsm("over_load", int'(IDLE), 0);

        // Reset two bits into a frame, then a clean frame 110.
        cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
        chk_fsm("pre_rst", int'(SHIFT), 2);
        cycle(1, 1, 1, 1);
        chk_out("mid_rst", 3'b000, 1'b0, 1'b0);
        chk_fsm("mid_rst", int'(IDLE), 0);
        cycle(0, 1, 1, 0); cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        chk_out("post_rst", 3'b110, 1'b1, 1'b0);
        cycle(0, 0, 0, 0);
        chk_out("post_rst_idle", 3'b110, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
